// File: rtl/mem_ctrl.sv
// mem_ctrl: requester-side controller for a single-port synchronous 16-bit word RAM.
// Converts CPU load/store requests (word or byte) into RAM enable/write/address/data
// cycles. Byte stores are done as a read-modify-write of the containing word.
// Every output is decoded from registered state; no input reaches an output
// combinationally.
module mem_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req,
  input  logic        I_write,
  input  logic        I_byte,
  input  logic        I_signed,
  input  logic [15:0] I_addr,
  input  logic [15:0] I_wdata,
  output logic        O_ack,
  output logic        O_err,
  output logic        O_busy,
  output logic [15:0] O_rdata,
  output logic        O_ram_en,
  output logic        O_ram_we,
  output logic [15:0] O_ram_addr,
  output logic [15:0] O_ram_data,
  input  logic [15:0] I_ram_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  // Request fields captured when a request is accepted in IDLE
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic        req_lane;
  logic        req_err;
  logic [7:0]  req_wbyte;

  logic [15:0] ram_addr_q;
  logic [15:0] ram_data_q;
  logic [15:0] rdata_q;

  logic        accept;
  logic        bad_req;

  // Select the addressed byte lane (or the whole word) and extend it to 16 bits
  function automatic logic [15:0] load_result(input logic [15:0] word,
                                              input logic        is_byte,
                                              input logic        is_signed,
                                              input logic        lane);
    logic signed [7:0]  lane_val;
    logic signed [15:0] ext;
    lane_val = lane ? word[15:8] : word[7:0];
    ext      = lane_val;
    if (!is_byte)
      return word;
    else if (is_signed)
      return ext;
    else
      return {8'h00, lane_val};
  endfunction

  // Replace one byte lane of the RAM word with the store byte
  function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                             input logic [7:0]  data,
                                             input logic        lane);
    return lane ? {data, word[7:0]} : {word[15:8], data};
  endfunction

  assign accept  = (state == IDLE) && I_req;
  // Reject addresses beyond the backed RAM and misaligned word accesses
  assign bad_req = ((I_addr >> ADDR_W) != 16'd0) || (!I_byte && I_addr[0]);

  // State register
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state and state-decoded control outputs
  always_comb begin
    state_next = state;
    O_ack      = 1'b0;
    O_err      = 1'b0;
    O_busy     = 1'b1;
    O_ram_en   = 1'b0;
    O_ram_we   = 1'b0;
    case (state)
      IDLE: begin
        O_busy = 1'b0;
        if (I_req) begin
          if (bad_req)
            state_next = RESP;
          else if (I_write && !I_byte)
            state_next = WR_ISSUE;
          else
            state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        O_ram_en   = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        // Only byte stores reach RD_WAIT with a write pending
        state_next = req_write ? WR_ISSUE : RESP;
      end
      WR_ISSUE: begin
        O_ram_en   = 1'b1;
        O_ram_we   = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        O_ack      = 1'b1;
        O_err      = req_err;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request fields on acceptance
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      req_write  <= 1'b0;
      req_byte   <= 1'b0;
      req_signed <= 1'b0;
      req_lane   <= 1'b0;
      req_err    <= 1'b0;
      req_wbyte  <= 8'h00;
    end else if (accept) begin
      req_write  <= I_write;
      req_byte   <= I_byte;
      req_signed <= I_signed;
      req_lane   <= I_addr[0];
      req_err    <= bad_req;
      req_wbyte  <= I_wdata[7:0];
    end
  end

  // RAM word address: updated only for requests that will touch the RAM
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset)
      ram_addr_q <= 16'h0000;
    else if (accept && !bad_req)
      ram_addr_q <= {1'b0, I_addr[15:1]};
  end

  // RAM write data: full word for word stores, merged word for byte stores
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset)
      ram_data_q <= 16'h0000;
    else if (accept && !bad_req && I_write && !I_byte)
      ram_data_q <= I_wdata;
    else if (state == RD_WAIT && req_write)
      ram_data_q <= merge_byte(I_ram_data, req_wbyte, req_lane);
  end

  // Load result register, changed only when a load completes its RAM read
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset)
      rdata_q <= 16'h0000;
    else if (state == RD_WAIT && !req_write)
      rdata_q <= load_result(I_ram_data, req_byte, req_signed, req_lane);
  end

  assign O_ram_addr = ram_addr_q;
  assign O_ram_data = ram_data_q;
  assign O_rdata    = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: drives mem_ctrl against a simple registered-read RAM and compares
// every cycle with a request-level reference model (reference memory array,
// per-request latency and lane arithmetic).
module tb_mem_ctrl;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic        I_req;
  logic        I_write;
  logic        I_byte;
  logic        I_signed;
  logic [15:0] I_addr;
  logic [15:0] I_wdata;
  logic        O_ack;
  logic        O_err;
  logic        O_busy;
  logic [15:0] O_rdata;
  logic        O_ram_en;
  logic        O_ram_we;
  logic [15:0] O_ram_addr;
  logic [15:0] O_ram_data;
  logic [15:0] I_ram_data;

  int vectors     = 0;
  int miscompares = 0;

  // Expected outputs for the current cycle, written by the model
  logic        exp_ack, exp_err, exp_busy, exp_en, exp_we;
  logic [15:0] exp_addr, exp_data, exp_rdata;
  logic        chk_on = 1'b0;

  // RAM seen by the DUT and the model's own view of memory
  logic [15:0] ram     [64] = '{default: 16'h0000};
  logic [15:0] ref_mem [64] = '{default: 16'h0000};
  logic [15:0] ram_q = 16'h0000;

  mem_ctrl #(.ADDR_W(7)) dut (
    .I_clk      (I_clk),
    .I_reset    (I_reset),
    .I_req      (I_req),
    .I_write    (I_write),
    .I_byte     (I_byte),
    .I_signed   (I_signed),
    .I_addr     (I_addr),
    .I_wdata    (I_wdata),
    .O_ack      (O_ack),
    .O_err      (O_err),
    .O_busy     (O_busy),
    .O_rdata    (O_rdata),
    .O_ram_en   (O_ram_en),
    .O_ram_we   (O_ram_we),
    .O_ram_addr (O_ram_addr),
    .O_ram_data (O_ram_data),
    .I_ram_data (I_ram_data)
  );

  always #5 I_clk = ~I_clk;

  // Synchronous RAM with one-cycle registered read
  always @(posedge I_clk) begin
    if (O_ram_en) begin
      if (O_ram_we)
        ram[O_ram_addr[5:0]] <= O_ram_data;
      else
        ram_q <= ram[O_ram_addr[5:0]];
    end
  end
  assign I_ram_data = ram_q;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge I_clk) begin
    if (chk_on) begin
      cmp("ack",      {15'd0, O_ack},    {15'd0, exp_ack});
      cmp("err",      {15'd0, O_err},    {15'd0, exp_err});
      cmp("busy",     {15'd0, O_busy},   {15'd0, exp_busy});
      cmp("ram_en",   {15'd0, O_ram_en}, {15'd0, exp_en});
      cmp("ram_we",   {15'd0, O_ram_we}, {15'd0, exp_we});
      cmp("ram_addr", O_ram_addr, exp_addr);
      cmp("ram_data", O_ram_data, exp_data);
      cmp("rdata",    O_rdata,    exp_rdata);
    end
  end

  task automatic set_exp(input logic ack, input logic err, input logic busy,
                         input logic en, input logic we);
    exp_ack  = ack;
    exp_err  = err;
    exp_busy = busy;
    exp_en   = en;
    exp_we   = we;
  endtask

  task automatic scramble();
    I_write  = 1'($urandom_range(0, 1));
    I_byte   = 1'($urandom_range(0, 1));
    I_signed = 1'($urandom_range(0, 1));
    I_addr   = 16'($urandom);
    I_wdata  = 16'($urandom);
  endtask

  // Issue one request in the current (idle) cycle and model it to completion.
  // abort_k > 0 pulses reset in that cycle after acceptance.
  // Returns just after the edge that ends the ack cycle (or the reset cycle).
  task automatic issue(input logic w, input logic b, input logic s,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic hold, input int abort_k);
    logic        e;
    logic [15:0] word, res, merged, lane_val;
    int          idx, lat, ak;
    logic        aborted;
    e    = (a > 16'd127) || (!b && a[0]);
    idx  = int'(a[6:1]);
    word = ref_mem[idx];
    lane_val = a[0] ? (word >> 8) : (word & 16'h00FF);
    if (!b)
      res = word;
    else if (s && lane_val >= 16'd128)
      res = lane_val | 16'hFF00;
    else
      res = lane_val;
    merged = a[0] ? ((word & 16'h00FF) | ({8'h00, wd[7:0]} << 8))
                  : ((word & 16'hFF00) | {8'h00, wd[7:0]});
    lat  = e ? 1 : (w && !b) ? 2 : (!w ? 3 : 4);
    ak   = (abort_k > lat) ? 0 : abort_k;
    aborted = 1'b0;

    I_req = 1'b1; I_write = w; I_byte = b; I_signed = s; I_addr = a; I_wdata = wd;
    set_exp(0, 0, 0, 0, 0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge I_clk); #1;
      scramble();
      if (k == ak) begin
        I_reset = 1'b1; I_req = 1'b0;
        set_exp(0, 0, 0, 0, 0);
        exp_addr = 16'h0000; exp_data = 16'h0000; exp_rdata = 16'h0000;
        @(posedge I_clk); #1;
        I_reset = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (e)
        set_exp(1, 1, 1, 0, 0);
      else if (k == lat) begin
        set_exp(1, 0, 1, 0, 0);
        if (!w) exp_rdata = res;
      end else if (k == 1) begin
        exp_addr = a >> 1;
        set_exp(0, 0, 1, 1, w && !b);
        if (w && !b) begin
          exp_data = wd;
          ref_mem[idx] = wd;
        end
      end else if (k == 3) begin
        set_exp(0, 0, 1, 1, 1);
        exp_data = merged;
        ref_mem[idx] = merged;
      end else
        set_exp(0, 0, 1, 0, 0);
    end
    if (!aborted) begin
      @(posedge I_clk); #1;
      I_req = hold;
      if (!hold) scramble();
      set_exp(0, 0, 0, 0, 0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge I_clk); #1;
      I_req = 1'b0;
      scramble();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w, b, s;
    logic [15:0] a, wd;
    int          ak;

    I_reset = 1'b1; I_req = 1'b0; I_write = 1'b0; I_byte = 1'b0; I_signed = 1'b0;
    I_addr = 16'h0000; I_wdata = 16'h0000;
    set_exp(0, 0, 0, 0, 0);
    exp_addr = 16'h0000; exp_data = 16'h0000; exp_rdata = 16'h0000;
    chk_on = 1'b1;
    @(posedge I_clk); @(posedge I_clk); #1;
    I_reset = 1'b0;

    // Word store then word load
    issue(1, 0, 0, 16'h0004, 16'h1234, 0, 0);
    issue(0, 0, 0, 16'h0004, 16'h0000, 0, 0);
    cmp("t1_rdata", O_rdata, 16'h1234);
    cmp("t1_model_rdata", exp_rdata, 16'h1234);
    cmp("t1_ram_addr", O_ram_addr, 16'h0002);

    // Byte store into the high lane
    issue(1, 1, 0, 16'h0005, 16'h00AB, 0, 0);
    cmp("t2_ram_word", ram[2], 16'hAB34);
    cmp("t2_model_word", ref_mem[2], 16'hAB34);
    issue(0, 0, 0, 16'h0004, 16'h0000, 0, 0);
    cmp("t2_rdata", O_rdata, 16'hAB34);

    // Byte loads, signed and unsigned
    issue(0, 1, 1, 16'h0005, 16'h0000, 0, 0);
    cmp("t3_signed_hi", O_rdata, 16'hFFAB);
    cmp("t3_model_signed", exp_rdata, 16'hFFAB);
    issue(0, 1, 0, 16'h0005, 16'h0000, 0, 0);
    cmp("t3_unsigned_hi", O_rdata, 16'h00AB);
    issue(0, 1, 1, 16'h0004, 16'h0000, 0, 0);
    cmp("t3_signed_lo", O_rdata, 16'h0034);

    // Rejected requests leave O_rdata untouched
    issue(0, 0, 0, 16'h0003, 16'h0000, 0, 0);
    cmp("t4_misaligned_rdata", O_rdata, 16'h0034);
    issue(1, 1, 0, 16'h0080, 16'h00EE, 0, 0);
    issue(0, 0, 0, 16'h0080, 16'h0000, 0, 0);
    cmp("t4_range_rdata", O_rdata, 16'h0034);

    // Reset during RD_WAIT, word-store WR_ISSUE and byte-store WR_ISSUE
    issue(0, 0, 0, 16'h0004, 16'h0000, 0, 2);
    cmp("t5_rdata_cleared", O_rdata, 16'h0000);
    issue(1, 0, 0, 16'h0004, 16'h5555, 0, 1);
    cmp("t5_word_kept_a", ram[2], 16'hAB34);
    issue(1, 1, 0, 16'h0004, 16'h0077, 0, 3);
    cmp("t5_word_kept_b", ram[2], 16'hAB34);
    issue(0, 0, 0, 16'h0004, 16'h0000, 0, 0);
    cmp("t5_after_reset", O_rdata, 16'hAB34);

    // Back-to-back loads with I_req held high
    issue(1, 0, 0, 16'h0010, 16'h1111, 0, 0);
    issue(1, 0, 0, 16'h0012, 16'h2222, 0, 0);
    issue(1, 0, 0, 16'h0014, 16'h3333, 0, 0);
    issue(0, 0, 0, 16'h0010, 16'h0000, 1, 0);
    cmp("t6_first", O_rdata, 16'h1111);
    issue(0, 0, 0, 16'h0012, 16'h0000, 1, 0);
    cmp("t6_second", O_rdata, 16'h2222);
    issue(0, 0, 0, 16'h0014, 16'h0000, 0, 0);
    cmp("t6_third", O_rdata, 16'h3333);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 127));
      if (!b && $urandom_range(0, 7) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 11) == 0) a = 16'($urandom) | 16'h0080;
      wd = 16'($urandom);
      ak = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 4)) : 0;
      issue(w, b, s, a, wd, 0, ak);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 64; i++)
      cmp($sformatf("mem_%0d", i), ram[i], ref_mem[i]);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
